// File: rtl/serial_addsub32.sv
// -----------------------------------------------------------------------------
// serial_addsub32
//
// Byte-serial modular adder/subtractor for an 8-bit serialized datapath.
// Two NBYTES-wide operands arrive one byte pair per cycle, least-significant
// byte first. Each pair goes through a single 8-bit add-with-carry slice. The
// carry (or inverted borrow, for subtract) is held in carry_q between bytes.
// Subtraction is computed as A + ~B + 1, with the +1 injected by presetting
// carry_q to 1 at start.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a word operation (sampled only in IDLE)
//   sub        operation select, sampled with start: 0 = A+B, 1 = A-B
//   a_in       operand A byte, LSB first
//   b_in       operand B byte, LSB first
//   in_valid   byte pair on a_in/b_in is valid
//   in_ready   block accepts a byte pair this cycle
//   sum_out    registered result byte
//   out_valid  sum_out holds an unconsumed byte
//   out_ready  downstream consumes sum_out this cycle
//   last       sum_out is the final (most significant) byte of the word
//   carry_out  final carry of the word; for subtract, 1 means no borrow
//   busy       high in any state except IDLE
//   done       one-cycle pulse after the final byte is consumed
// -----------------------------------------------------------------------------
module serial_addsub32 #(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sub,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] sum_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       last,
  output logic       carry_out,
  output logic       busy,
  output logic       done
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic          mode_q,      mode_d;
  logic          carry_q,     carry_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [7:0]    sum_q,       sum_d;
  logic          out_valid_q, out_valid_d;
  logic          last_q,      last_d;
  logic          carry_out_q, carry_out_d;
  logic          done_q,      done_d;

  logic          accept;
  logic          consume;
  logic          final_byte;
  logic [7:0]    b_eff;
  logic [8:0]    slice;

  // ---------------------------------------------------------------------------
  // Handshake and arithmetic slice
  // ---------------------------------------------------------------------------
  // in_ready deliberately depends only on state, out_valid and out_ready, so
  // nothing on the a_in/b_in side can ripple combinationally to an output.
  always_comb begin
    in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
    accept     = in_ready && in_valid;
    consume    = out_valid_q && out_ready;
    final_byte = (cnt_q == LAST_IDX);
    b_eff      = mode_q ? ~b_in : b_in;
    // 9-bit sum so the carry out of the byte lands in slice[8].
    slice      = {1'b0, a_in} + {1'b0, b_eff} + {8'd0, carry_q};
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch instead of combinational logic.
    state_d     = state_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    carry_out_d = carry_out_q;
    done_d      = 1'b0;

    // Output register: a new byte wins over a consume on the same edge, so a
    // simultaneous accept+consume keeps out_valid high with the fresh byte.
    if (accept) begin
      sum_d       = slice[7:0];
      out_valid_d = 1'b1;
      last_d      = final_byte;
      carry_d     = slice[8];
      cnt_d       = final_byte ? '0 : cnt_q + CW'(1);
      if (final_byte) begin
        carry_out_d = slice[8];
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          mode_d      = sub;
          // Subtract is A + ~B + 1: the +1 enters as the initial carry.
          carry_d     = sub;
          cnt_d       = '0;
          carry_out_d = 1'b0;
        end
      end
      RUN: begin
        if (accept && final_byte) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // out_valid is always set on entry to DRAIN (the final byte was just
        // loaded), so a consume here is always the final byte.
        if (consume) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= 8'd0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      carry_out_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      carry_out_q <= carry_out_d;
      done_q      <= done_d;
    end
  end

  assign sum_out   = sum_q;
  assign out_valid = out_valid_q;
  assign last      = last_q;
  assign carry_out = carry_out_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
